sipo_deserializer: RTL
======================

# sipo_deserializer

Serial-in, parallel-out frame deserializer that sits directly downstream of the team's parallel-in serial-out shift stage. It collects WIDTH serial bits into a word, using a per-frame sync marker for alignment. It presents the word on a valid/ready parallel interface through a one-entry output buffer. It flags overruns and mid-frame resyncs through sticky status bits.

## Interface
Parameters:
- WIDTH, default 4: bits per frame; legal range 2..32.
- MSB_FIRST, default 1: 1 places the first received bit in pdata[WIDTH-1]; 0 places it in pdata[0].

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_sync  input  1  with sin_valid: this bit is bit 0 of a new frame.
- pdata  output  WIDTH  assembled word; stable while pvalid=1.
- pvalid  output  1  pdata holds an unconsumed word.
- pready  input  1  consumer accepts pdata when pvalid&&pready at a clock edge.
- overrun  output  1  sticky: a completed word was dropped.
- sync_err  output  1  sticky: sin_sync arrived mid-frame.
- clr_err  input  1  synchronous clear of overrun and sync_err.

## Operation
- Two-state FSM: IDLE and SHIFT. A bit counter (clog2(WIDTH)+1 bits) and a WIDTH-bit shift register run alongside the FSM.
- IDLE behaviour:
  - sin_valid=1 with sin_sync=1: the bit is captured as frame bit 0, count=1, and the FSM goes to SHIFT.
  - sin_valid=1 with sin_sync=0: the bit is ignored.
- SHIFT behaviour:
  - sin_valid=1 with sin_sync=0: the bit is shifted in and count increments.
  - sin_valid=0: state, count and shift register hold. There is no timeout.
  - sin_valid=1 with sin_sync=1: the partial frame is discarded, sync_err is set, the bit starts a new frame as bit 0 with count=1, and the FSM stays in SHIFT.
- Frame completion:
  - The edge that accepts bit WIDTH-1 completes the frame. The full word, including that bit, goes to the output buffer on that same edge.
  - The FSM returns to IDLE and count resets to 0.
- Bit order:
  - MSB_FIRST=1: the shift register shifts left and frame bit i lands in pdata[WIDTH-1-i].
  - MSB_FIRST=0: the shift register shifts right and frame bit i lands in pdata[i].
- Output buffer (one entry):
  - Completion with pvalid=0: pdata is loaded and pvalid is set to 1.
  - pvalid&&pready with no completion on the same edge: pvalid is cleared and pdata holds its last value.
  - Completion on the same edge as pvalid&&pready: the old word is consumed, the new word is loaded, and pvalid stays 1.
  - Completion with pvalid=1 and pready=0: the new word is dropped, pdata is unchanged, and overrun is set.
- Status flags:
  - clr_err=1 clears both overrun and sync_err.
  - A set event on the same edge as clr_err wins, so the flag reads 1 afterward.

## Timing
- Reset values: pdata=0, pvalid=0, overrun=0, sync_err=0. FSM=IDLE, count=0, shift register=0.
- Asserting reset mid-frame discards the partial frame and any buffered word.
- Latency: with the last bit accepted at edge k, pvalid=1 and the new pdata are visible immediately after edge k.
- Minimum frame time is WIDTH consecutive sin_valid cycles.
- Back-to-back frames are supported with no gap: after completion, IDLE accepts a sync bit on the very next edge.
- Sustained throughput is one word per WIDTH cycles, provided pready is not held low across a completion.
- pvalid never drops without a handshake. pdata never changes while pvalid=1 except on a handshake edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Scenarios use WIDTH=4 and MSB_FIRST=1 unless stated otherwise.
- Basic frame: bits 1,0,1,1 on consecutive cycles with sync on the first bit and pready=1 → pdata=4'b1011 with pvalid=1 for exactly one cycle after the 4th edge, then pvalid=0.
- Bit order and gaps: MSB_FIRST=0, same bits with sin_valid low for 3 cycles between bits 2 and 3 → pdata=4'b1101. Bits with no sync while IDLE are ignored.
- Backpressure and overrun: pready=0, send frames 0xA then 0x5 → pdata stays 0xA and overrun=1. Then pready=1 → 0xA consumed. clr_err → overrun=0.
- Simultaneous completion and handshake: pvalid=1 (0x3) with pready=1 on the edge completing 0xC → pdata=0xC, pvalid stays 1, overrun=0.
- Mid-frame resync: send bits 1,1 then a sync bit 0 followed by 1,1,0 → sync_err=1 and pdata=4'b0110. clr_err on the same edge as a new sync_err event → sync_err stays 1.
- Reset mid-frame: assert reset after 2 bits with pvalid=1 → all outputs 0 asynchronously. A following full frame 0x9 is received correctly.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out frame deserializer with sync-marker alignment,
// a one-entry valid/ready output buffer and sticky overrun/resync flags.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_sync,
    output logic [WIDTH-1:0] pdata,
    output logic             pvalid,
    input  logic             pready,
    output logic             overrun,
    output logic             sync_err,
    input  logic             clr_err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] w_base;
    logic             w_take;
    logic             w_complete;
    logic             w_sync_evt;

    logic [WIDTH-1:0] r_pdata;
    logic             r_pvalid;
    logic             r_overrun;
    logic             r_sync_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sreg  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sreg  <= w_sreg_nxt;
        end
    end

    // A sync bit always restarts assembly from an empty register and count 0,
    // whether it opens a frame from IDLE or aborts a partial one in SHIFT.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sreg_nxt  = r_sreg;
        w_base      = r_sreg;
        w_cnt_base  = r_cnt;
        w_cnt_inc   = '0;
        w_take      = 1'b0;
        w_complete  = 1'b0;
        w_sync_evt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (sin_valid && sin_sync) begin
                    w_take = 1'b1;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    w_take     = 1'b1;
                    w_sync_evt = sin_sync;
                end
            end
            default: ;
        endcase

        if (w_take && sin_sync) begin
            w_base     = '0;
            w_cnt_base = '0;
        end

        if (w_take) begin
            w_sreg_nxt = MSB_FIRST ? {w_base[WIDTH-2:0], sin} : {sin, w_base[WIDTH-1:1]};
            w_cnt_inc  = w_cnt_base + CNT_W'(1);
            if (w_cnt_inc == CNT_FULL) begin
                w_complete  = 1'b1;
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = SHIFT;
                w_cnt_nxt   = w_cnt_inc;
            end
        end
    end

    // Output buffer: a completing word replaces the held one only if the
    // held one is empty or being consumed on this edge; otherwise it is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pdata    <= '0;
            r_pvalid   <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            if (w_complete) begin
                if (!r_pvalid || pready) begin
                    r_pdata  <= w_sreg_nxt;
                    r_pvalid <= 1'b1;
                end
            end else if (r_pvalid && pready) begin
                r_pvalid <= 1'b0;
            end

            if (w_complete && r_pvalid && !pready) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end

            if (w_sync_evt) begin
                r_sync_err <= 1'b1;
            end else if (clr_err) begin
                r_sync_err <= 1'b0;
            end
        end
    end

    assign pdata    = r_pdata;
    assign pvalid   = r_pvalid;
    assign overrun  = r_overrun;
    assign sync_err = r_sync_err;

endmodule
